// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared write-response arbiter states and AXI bresp codes
package axi_ic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } br_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/br_rr_grant.sv
// rtl/br_rr_grant.sv - two-requester round-robin grant with its own priority pointer
module br_rr_grant (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic prio_d;
    logic prio_q;

    // On a tie the pointer picks the winner; afterwards it points at the loser.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        prio_d  = prio_q;
        if (en) begin
            if (req[0] && (!req[1] || !prio_q)) begin
                gnt     = 2'b01;
                gnt_idx = 1'b0;
                prio_d  = 1'b1;
            end else if (req[1]) begin
                gnt     = 2'b10;
                gnt_idx = 1'b1;
                prio_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/br_resp_rr_arbiter.sv
// rtl/br_resp_rr_arbiter.sv - B-channel round-robin arbiter/router; Err_Count added under BR_ARB_ERR_CNT_EN
module br_resp_rr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int                         Num_Of_Masters  = 2,
    parameter int                         Master_ID_Width = $clog2(Num_Of_Masters),
    parameter logic [Master_ID_Width-1:0] M1_ID           = 'd0,
    parameter logic [Master_ID_Width-1:0] M2_ID           = 'd1
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [Master_ID_Width-1:0] M00_AXI_BID,
    input  logic [1:0]                 M00_AXI_bresp,
    input  logic                       M00_AXI_bvalid,
    output logic                       M00_AXI_bready,
    input  logic [Master_ID_Width-1:0] M01_AXI_BID,
    input  logic [1:0]                 M01_AXI_bresp,
    input  logic                       M01_AXI_bvalid,
    output logic                       M01_AXI_bready,
    output logic [1:0]                 S00_AXI_bresp,
    output logic                       S00_AXI_bvalid,
    input  logic                       S00_AXI_bready,
    output logic [1:0]                 S01_AXI_bresp,
    output logic                       S01_AXI_bvalid,
    input  logic                       S01_AXI_bready
`ifdef BR_ARB_ERR_CNT_EN
    ,
    output logic [7:0]                 Err_Count
`endif
);

    br_state_e                  state_d;
    br_state_e                  state_q;
    logic [Master_ID_Width-1:0] hold_id_d;
    logic [Master_ID_Width-1:0] hold_id_q;
    logic [1:0]                 hold_resp_d;
    logic [1:0]                 hold_resp_q;

    logic [1:0]                 gnt;
    logic                       gnt_idx;
    logic [Master_ID_Width-1:0] sel_id;
    logic [1:0]                 sel_resp;
    logic                       in_resp;
    logic                       route0;
    logic                       route1;

    br_rr_grant u_grant (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .en      (state_q == ST_IDLE),
        .req     ({M01_AXI_bvalid, M00_AXI_bvalid}),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        hold_id_d   = hold_id_q;
        hold_resp_d = hold_resp_q;
        sel_id      = gnt_idx ? M01_AXI_BID   : M00_AXI_BID;
        sel_resp    = gnt_idx ? M01_AXI_bresp : M00_AXI_bresp;
        route0      = (hold_id_q == M1_ID);
        route1      = (hold_id_q == M2_ID);
        if (state_q == ST_IDLE) begin
            if (gnt != 2'b00) begin
                hold_id_d   = sel_id;
                hold_resp_d = sel_resp;
                state_d     = ST_RESP;
            end
        end else begin
            // An ID that routes nowhere is dropped after a single RESP cycle.
            if (!route0 && !route1) begin
                state_d = ST_IDLE;
            end else if ((route0 && S00_AXI_bready) || (route1 && S01_AXI_bready)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            hold_id_q   <= '0;
            hold_resp_q <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            hold_id_q   <= hold_id_d;
            hold_resp_q <= hold_resp_d;
        end
    end

    // bready is gated by reset so it drops the instant ARESETN falls.
    assign M00_AXI_bready = gnt[0] & ARESETN;
    assign M01_AXI_bready = gnt[1] & ARESETN;

    assign in_resp        = (state_q == ST_RESP);
    assign S00_AXI_bvalid = in_resp & route0;
    assign S01_AXI_bvalid = in_resp & route1;
    assign S00_AXI_bresp  = in_resp ? hold_resp_q : RESP_OKAY;
    assign S01_AXI_bresp  = in_resp ? hold_resp_q : RESP_OKAY;

`ifdef BR_ARB_ERR_CNT_EN
    logic [7:0] err_cnt_d;
    logic [7:0] err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((gnt != 2'b00) && resp_is_err(sel_resp) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Err_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_br_resp_rr_arbiter.sv
// tb/tb_br_resp_rr_arbiter.sv - randomized and directed bench for br_resp_rr_arbiter against a response-level model
module tb_br_resp_rr_arbiter;

    localparam int         IDW = 2;
    localparam logic [1:0] ID0 = 2'd0;
    localparam logic [1:0] ID1 = 2'd1;

    logic           ACLK = 1'b0;
    logic           ARESETN;
    logic [IDW-1:0] M00_AXI_BID, M01_AXI_BID;
    logic [1:0]     M00_AXI_bresp, M01_AXI_bresp;
    logic           M00_AXI_bvalid, M01_AXI_bvalid;
    logic           M00_AXI_bready, M01_AXI_bready;
    logic [1:0]     S00_AXI_bresp, S01_AXI_bresp;
    logic           S00_AXI_bvalid, S01_AXI_bvalid;
    logic           S00_AXI_bready, S01_AXI_bready;
`ifdef BR_ARB_ERR_CNT_EN
    logic [7:0]     Err_Count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: at most one response in flight, plus whose turn it is on a tie.
    bit         m_busy = 0;
    logic [1:0] m_id   = '0;
    logic [1:0] m_resp = '0;
    int         m_turn = 0;
    int         m_err  = 0;

    br_resp_rr_arbiter #(
        .Num_Of_Masters  (2),
        .Master_ID_Width (IDW),
        .M1_ID           (ID0),
        .M2_ID           (ID1)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .M00_AXI_BID    (M00_AXI_BID),
        .M00_AXI_bresp  (M00_AXI_bresp),
        .M00_AXI_bvalid (M00_AXI_bvalid),
        .M00_AXI_bready (M00_AXI_bready),
        .M01_AXI_BID    (M01_AXI_BID),
        .M01_AXI_bresp  (M01_AXI_bresp),
        .M01_AXI_bvalid (M01_AXI_bvalid),
        .M01_AXI_bready (M01_AXI_bready),
        .S00_AXI_bresp  (S00_AXI_bresp),
        .S00_AXI_bvalid (S00_AXI_bvalid),
        .S00_AXI_bready (S00_AXI_bready),
        .S01_AXI_bresp  (S01_AXI_bresp),
        .S01_AXI_bvalid (S01_AXI_bvalid),
        .S01_AXI_bready (S01_AXI_bready)
`ifdef BR_ARB_ERR_CNT_EN
        ,
        .Err_Count      (Err_Count)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_id   = '0;
        m_resp = '0;
        m_turn = 0;
        m_err  = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic run_cycle(input logic v0, input logic [1:0] id0, input logic [1:0] r0,
                             input logic v1, input logic [1:0] id1, input logic [1:0] r1,
                             input logic sr0, input logic sr1);
        int   winner;
        int   dest;
        logic rdy [2];
        @(negedge ACLK);
        M00_AXI_bvalid = v0;  M00_AXI_BID = id0;  M00_AXI_bresp = r0;
        M01_AXI_bvalid = v1;  M01_AXI_BID = id1;  M01_AXI_bresp = r1;
        S00_AXI_bready = sr0; S01_AXI_bready = sr1;
        rdy[0] = sr0; rdy[1] = sr1;
        winner = -1;
        if (!m_busy) begin
            if (v0 && v1)  winner = m_turn;
            else if (v0)   winner = 0;
            else if (v1)   winner = 1;
        end
        dest = (m_id == ID0) ? 0 : (m_id == ID1) ? 1 : -1;
        #1;
        check("m00_bready", M00_AXI_bready, winner == 0);
        check("m01_bready", M01_AXI_bready, winner == 1);
        check("s00_bvalid", S00_AXI_bvalid, m_busy && dest == 0);
        check("s01_bvalid", S01_AXI_bvalid, m_busy && dest == 1);
        check("s00_bresp",  S00_AXI_bresp,  m_busy ? m_resp : 2'b00);
        check("s01_bresp",  S01_AXI_bresp,  m_busy ? m_resp : 2'b00);
`ifdef BR_ARB_ERR_CNT_EN
        check("err_count",  Err_Count,      m_err);
`endif
        @(posedge ACLK);
        if (winner >= 0) begin
            m_busy = 1;
            m_id   = (winner == 0) ? id0 : id1;
            m_resp = (winner == 0) ? r0  : r1;
            m_turn = 1 - winner;
            if (m_resp != 2'b00 && m_err < 255) m_err++;
        end else if (m_busy) begin
            if (dest < 0 || rdy[dest]) m_busy = 0;
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        M00_AXI_bvalid = 0; M00_AXI_BID = '0; M00_AXI_bresp = '0;
        M01_AXI_bvalid = 0; M01_AXI_BID = '0; M01_AXI_bresp = '0;
        S00_AXI_bready = 0; S01_AXI_bready = 0;
        model_reset();
        #12;
        check("rst_s00_bvalid", S00_AXI_bvalid, 0);
        check("rst_s01_bvalid", S01_AXI_bvalid, 0);
        check("rst_bresp",      {S00_AXI_bresp, S01_AXI_bresp}, 0);
        check("rst_bready",     {M00_AXI_bready, M01_AXI_bready}, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single response: grant, deliver, back to idle.
        run_cycle(1, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 0);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 0);
        run_cycle(0, 2'd0, 2'b00, 1, 2'd1, 2'b10, 0, 1);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 0, 1);

        // Tie held high: alternating service.
        for (int i = 0; i < 8; i++) run_cycle(1, 2'd0, 2'b00, 1, 2'd1, 2'b10, 1, 1);

        // Backpressure on S01 while other traffic and bresp inputs churn.
        run_cycle(0, 2'd0, 2'b00, 1, 2'd1, 2'b11, 0, 0);
        for (int i = 0; i < 5; i++) run_cycle(1, 2'd0, 2'(i), 1, 2'd1, 2'(i + 1), 1, 0);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd1, 2'b00, 0, 1);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 0, 0);

        // Unmatched ID is dropped after one cycle.
        run_cycle(1, 2'd3, 2'b11, 0, 2'd0, 2'b00, 0, 0);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 0, 0);
        run_cycle(0, 2'd0, 2'b00, 1, 2'd2, 2'b10, 0, 0);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 0, 0);

        // Asynchronous reset while S00 holds a response.
        run_cycle(1, 2'd0, 2'b10, 0, 2'd0, 2'b00, 0, 0);
        @(negedge ACLK);
        M00_AXI_bvalid = 1; M01_AXI_bvalid = 1; M01_AXI_BID = 2'd1;
        #1;
        check("pre_rst_s00_bvalid", S00_AXI_bvalid, 1);
        #1;
        ARESETN = 1'b0;
        #1;
        check("arst_s00_bvalid", S00_AXI_bvalid, 0);
        check("arst_s01_bvalid", S01_AXI_bvalid, 0);
        check("arst_bready",     {M00_AXI_bready, M01_AXI_bready}, 0);
        check("arst_bresp",      {S00_AXI_bresp, S01_AXI_bresp}, 0);
        model_reset();
        @(negedge ACLK);
        M00_AXI_bvalid = 0; M01_AXI_bvalid = 0;
        ARESETN = 1'b1;
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 1);
        check("after_rst_no_stale", {S00_AXI_bvalid, S01_AXI_bvalid}, 0);
        run_cycle(1, 2'd0, 2'b00, 1, 2'd1, 2'b00, 1, 1);
        check("tie_after_rst_m00", M00_AXI_bready, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

`ifdef BR_ARB_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            run_cycle(1, 2'd0, 2'b10, 0, 2'd0, 2'b00, 1, 1);
            run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 1);
        end
        check("err_cnt_sat", Err_Count, 8'hFF);
        run_cycle(1, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 1);
        run_cycle(0, 2'd0, 2'b00, 0, 2'd0, 2'b00, 1, 1);
        check("err_cnt_okay_hold", Err_Count, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/br_resp_rr_arbiter.md
BR_RESP_RR_ARBITER -- requirements
Module: br_resp_rr_arbiter

Interface
REQ-001 SHALL have parameter Num_Of_Masters, default 2: number of write-response sources and destinations.
REQ-002 SHALL have parameter Master_ID_Width, default $clog2(Num_Of_Masters): width of BID.
REQ-003 SHALL have parameter M1_ID, default 'd0: BID value routed to S00.
REQ-004 SHALL have parameter M2_ID, default 'd1: BID value routed to S01.
REQ-005 SHALL have port ACLK, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port ARESETN, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports M00_AXI_BID / M01_AXI_BID, input, Master_ID_Width: response ID from source 0/1.
REQ-008 SHALL have ports M00_AXI_bresp / M01_AXI_bresp, input, 2: response code from source 0/1.
REQ-009 SHALL have ports M00_AXI_bvalid / M01_AXI_bvalid, input, 1: response valid from source 0/1.
REQ-010 SHALL have ports M00_AXI_bready / M01_AXI_bready, output, 1: response accept to source 0/1.
REQ-011 SHALL have ports S00_AXI_bresp / S01_AXI_bresp, output, 2: response code to master 0/1.
REQ-012 SHALL have ports S00_AXI_bvalid / S01_AXI_bvalid, output, 1: response valid to master 0/1.
REQ-013 SHALL have ports S00_AXI_bready / S01_AXI_bready, input, 1: response ready from master 0/1.

Function
REQ-014 SHALL implement the FSM states IDLE and RESP, with a one-entry holding register {BID, bresp} and a 1-bit round-robin pointer Prio.
REQ-015 In IDLE with exactly one source bvalid high, SHALL grant that source.
REQ-016 In IDLE with both sources bvalid high, SHALL grant source Prio; the other source waits.
REQ-017 In IDLE, SHALL drive the granted source's bready high combinationally in the same cycle; all other bready outputs SHALL be 0.
REQ-018 On the IDLE grant edge, SHALL capture BID/bresp into the holding register, set Prio to the non-granted index, and go to RESP.
REQ-019 In RESP, SHALL assert S00_AXI_bvalid when the held BID equals M1_ID, S01_AXI_bvalid when it equals M2_ID, and drive the held bresp on both S0x_AXI_bresp outputs.
REQ-020 In RESP, all M0x_AXI_bready outputs SHALL be 0.
REQ-021 In RESP, bvalid and bresp SHALL stay stable until the routed S0x_AXI_bready is sampled high; on that edge, SHALL return to IDLE.
REQ-022 A held BID matching neither M1_ID nor M2_ID SHALL be dropped: no S0x bvalid is asserted, and the FSM returns to IDLE on the next edge.
REQ-023 Latency SHALL be 1 cycle from the source handshake to S0x bvalid; peak throughput SHALL be one response per 2 cycles.
REQ-024 S0x_AXI_bready high while the corresponding S0x bvalid is low SHALL have no effect.
REQ-025 New source bvalid arriving during RESP SHALL NOT be accepted until the FSM is back in IDLE.

Reset
REQ-026 ARESETN low SHALL immediately force: state IDLE, Prio 0, holding register 0, all bvalid/bready outputs 0, all bresp outputs 2'b00.
REQ-027 Reset asserted during RESP SHALL discard the held response; no S0x bvalid is issued after reset release.
REQ-028 The first grant after reset SHALL follow Prio=0, i.e. source 0 wins a tie.

Configuration
REQ-029 With macro BR_ARB_ERR_CNT_EN defined, SHALL add output Err_Count[7:0], reset to 0.
REQ-030 With BR_ARB_ERR_CNT_EN defined, Err_Count SHALL increment on each IDLE grant whose bresp != 2'b00, and SHALL saturate at 8'hFF.
REQ-031 Without BR_ARB_ERR_CNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE=1'b0, RESP=1'b1) and the bresp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) in the shared package axi_ic_pkg.
REQ-033 SHALL implement the tie-break and pointer update in one sub-module, br_rr_grant (2-requester round-robin); everything else stays in the top module.

Verification
REQ-034 Single response: M00 bvalid, BID=0, bresp=00 at cycle 0 -> M00 bready=1 at cycle 0; S00 bvalid=1, bresp=00 at cycle 1; with S00 bready=1, IDLE at cycle 2.
REQ-035 Tie: both bvalid with BID0=0 and BID1=1, held high -> grants in order M00, M01, M00; S00 then S01 each receive bvalid; each source is served once per 4 cycles.
REQ-036 Backpressure: S01 bready=0 for 5 cycles during RESP -> S01 bvalid and bresp stay stable for 5 cycles, both M0x bready stay 0, and completion follows the first S01 bready=1.
REQ-037 Unmatched ID: BID=3 with Master_ID_Width=2 -> bready handshake completes, no S0x bvalid is asserted, and the FSM is back in IDLE after 2 cycles.
REQ-038 Reset mid-RESP: ARESETN low while S00 bvalid=1 -> all outputs 0 asynchronously; after release, no stale bvalid appears and a tie grants M00.
REQ-039 With BR_ARB_ERR_CNT_EN: 300 responses with bresp=2'b10 -> Err_Count=8'hFF, and an OKAY response leaves it unchanged.
